morse_player: RTL

Parametrised Morse-code playback engine. It replaces the fixed 14-bit shift-and-blink encoder: a symbol is selected, its on/off pattern is fetched with an explicit length, and the pattern is played one bit per time unit on a single LED output. It adds a start/busy/done handshake, abort, and an optional repeat mode with an inter-word gap. It sits between the board switches/keys and an LEDR bit, clocked from CLOCK_50.

---
 rtl/morse_pkg.sv | 32 +++
 rtl/morse_rom.sv | 26 ++
 rtl/morse_player.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse symbol table, FSM state type and default timing
package morse_pkg;

  localparam int MORSE_PAT_W       = 14;
  localparam int MORSE_LEN_W       = 4;
  localparam int MORSE_SEL_W       = 3;
  localparam int DEFAULT_CLK_DIV   = 12500000;
  localparam int DEFAULT_GAP_UNITS = 7;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_e;

  // Literals are written MSB first, so the played order reads right to left.
  localparam logic [MORSE_PAT_W-1:0] SYM_PAT [2**MORSE_SEL_W] = '{
    14'b00000000010101,  // S
    14'b00000000000111,  // T
    14'b00000001110101,  // U
    14'b00000111010101,  // V
    14'b00000111011101,  // W
    14'b00011101010111,  // X
    14'b01110111010111,  // Y
    14'b00010101110111   // Z
  };

  localparam logic [MORSE_LEN_W-1:0] SYM_LEN [2**MORSE_SEL_W] = '{
    4'd5, 4'd3, 4'd7, 4'd9, 4'd9, 4'd11, 4'd13, 4'd11
  };

endpackage

// File: rtl/morse_rom.sv
// rtl/morse_rom.sv - Combinational symbol index to {pattern, length} lookup
module morse_rom
  import morse_pkg::*;
#(
  parameter int PAT_W = MORSE_PAT_W,
  parameter int LEN_W = MORSE_LEN_W,
  parameter int SEL_W = MORSE_SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [PAT_W-1:0] pat_o,
  output logic [LEN_W-1:0] len_o
);

  // Indices beyond the table return an empty pattern of length 0.
  always_comb begin
    pat_o = '0;
    len_o = '0;
    for (int i = 0; i < 2**MORSE_SEL_W; i++) begin
      if (int'(sel_i) == i) begin
        pat_o = PAT_W'(SYM_PAT[i]);
        len_o = LEN_W'(SYM_LEN[i]);
      end
    end
  end

endmodule

// File: rtl/morse_player.sv
// rtl/morse_player.sv - Morse playback FSM with unit divider, repeat gap and abort
module morse_player
  import morse_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int PAT_W     = MORSE_PAT_W,
  parameter int LEN_W     = MORSE_LEN_W,
  parameter int SEL_W     = MORSE_SEL_W,
  parameter int GAP_UNITS = DEFAULT_GAP_UNITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int                TICK_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_UNITS - 1);

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  shift_q, shift_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bit_q, bit_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        gap_q, gap_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PAT_W-1:0]  rom_pat;
  logic [LEN_W-1:0]  rom_len;
  logic              unit_end;

  morse_rom #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W),
    .SEL_W(SEL_W)
  ) u_rom (
    .sel_i(sel),
    .pat_o(rom_pat),
    .len_o(rom_len)
  );

  assign unit_end = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pat_d   = pat_q;
    len_d   = len_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    gap_d   = gap_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      led_d   = 1'b0;
      busy_d  = 1'b0;
      tick_d  = '0;
      bit_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (rom_len == '0) begin
              done_d = 1'b1;
            end else begin
              // The pattern is kept twice: one copy shifts, the other reloads each repeat.
              state_d = PLAY;
              pat_d   = rom_pat;
              shift_d = rom_pat;
              len_d   = rom_len;
              bit_d   = '0;
              tick_d  = '0;
              led_d   = rom_pat[0];
              busy_d  = 1'b1;
            end
          end
        end
        PLAY: begin
          tick_d = unit_end ? '0 : tick_q + 1'b1;
          if (unit_end) begin
            if (bit_q == len_q - 1'b1) begin
              bit_d = '0;
              led_d = 1'b0;
              if (repeat_en) begin
                state_d = GAP;
                gap_d   = '0;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_q >> 1;
              led_d   = shift_q[1];
            end
          end
        end
        GAP: begin
          tick_d = unit_end ? '0 : tick_q + 1'b1;
          if (unit_end) begin
            if (gap_q == GAP_LAST) begin
              state_d = PLAY;
              shift_d = pat_q;
              bit_d   = '0;
              gap_d   = '0;
              led_d   = pat_q[0];
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      tick_q  <= '0;
      gap_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
